proc_0_pixel_reader: RTL
========================

# proc_0_pixel_reader

Avalon-MM read master that streams a contiguous run of 32-bit pixel words out of the processor's on-chip image memory. It sits directly upstream of the pixel-processing datapath and consumes the single-port memory's read port, with a fixed one-cycle read latency. It emits the words on a ready/valid stream with back-pressure, so the memory is never read faster than the consumer drains. The NIOS control side programs base and length and starts a transfer.

## Interface
- ADDR_W, 17, word-address width of the image memory
- DATA_W, 32, pixel word width
- MEM_WORDS, 75000, memory depth; the address wrap point
- FIFO_DEPTH, 4, output buffer depth in words (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start
- word_count  in  ADDR_W  number of words to read, sampled on start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the last word is accepted downstream
- mem_address  out  ADDR_W  memory word address
- mem_chipselect  out  1  read strobe (write held 0, byteenable held 4'hF, clken held 1)
- mem_readdata  in  DATA_W  memory data, valid the cycle after chipselect
- st_data  out  DATA_W  stream data
- st_valid  out  1  stream data valid
- st_ready  in  1  consumer ready
- st_sop, st_eop  out  1  packet flags (only with the macro below)

## Operation
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_data=0, st_sop=0, st_eop=0; FIFO empty; in-flight flag cleared.
- States: IDLE, FETCH, DRAIN, FINISH.
- IDLE: when start=1 and word_count≠0, latch base_addr and word_count, then go to FETCH. When start=1 and word_count=0, go to FINISH with no reads.
- FETCH: mem_chipselect asserts only when occupancy + in_flight < FIFO_DEPTH. Each issued read increments the address and decrements the remaining count. After the last read is issued, go to DRAIN.
- Address wrap: after MEM_WORDS-1, the next address is 0.
- In-flight: the word returned the cycle after chipselect is always written into the FIFO. The credit check guarantees the FIFO never overflows.
- DRAIN: wait until the FIFO is empty and no read is in flight, then go to FINISH.
- FINISH: done=1 for exactly one cycle, then return to IDLE.
- busy is high in FETCH, DRAIN and FINISH.
- Stream rules: st_data and st_valid come from the FIFO head. While st_valid=1 and st_ready=0, st_data holds stable. A transfer occurs when st_valid & st_ready.
- A simultaneous FIFO push and pop in the same cycle leaves occupancy unchanged.
- start while busy is ignored with no effect.
- Reset mid-transfer returns to IDLE immediately. In-flight data is discarded and no done pulse is produced.

## Timing
- start sampled at cycle 0. First mem_chipselect at cycle 1. Word captured at the end of cycle 2. First st_valid at cycle 3.
- With st_ready held at 1: one word per clock sustained. The last st_valid occurs at cycle N+2 for N words. done fires at cycle N+3.
- st_ready low: reads stop within one cycle once credits are exhausted. At most FIFO_DEPTH words are buffered.
- Back-to-back transfers: a start in the cycle after done is accepted.

## Configuration
- PROC_0_PIXEL_READER_PACKET_EN defined: st_sop is high with the first word of a transfer and st_eop with the last. Both flags are stored in the FIFO alongside the data and are 0 otherwise.
- Not defined: the st_sop and st_eop ports and their FIFO bits are absent. Packet boundaries are signalled only by done.

## Test plan
- Streaming read: base 0x00010, count 8, st_ready=1, memory holding address-as-data → st_data 0x10..0x17 on cycles 3..10, done pulse at cycle 11, sop on 0x10 and eop on 0x17 (macro on).
- Back-pressure: count 16 with st_ready toggling 1-0-0-1 → all 16 words delivered in order, no loss, FIFO occupancy never above 4, mem_chipselect low whenever credits are 0.
- Wrap-around: base 74998, count 4 → addresses 74998, 74999, 0, 1.
- Zero length: count 0 → no mem_chipselect, done pulse 1 cycle after start, busy high for exactly 1 cycle.
- start during busy: second start mid-transfer with a different base → ignored, first transfer completes unchanged.
- Reset mid-transfer: assert reset at word 3 of 8 → all outputs return to reset values asynchronously; a subsequent start of count 2 delivers exactly 2 words.

Source files
------------

// File: rtl/proc_0_pixel_reader.sv
// Avalon-MM read master streaming pixel words from image memory onto a ready/valid stream.
// Define PROC_0_PIXEL_READER_PACKET_EN to add st_sop/st_eop packet flags carried through the FIFO.
module proc_0_pixel_reader #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = 75000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready
`ifdef PROC_0_PIXEL_READER_PACKET_EN
  ,
  output logic                st_sop,
  output logic                st_eop
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef PROC_0_PIXEL_READER_PACKET_EN
  localparam int ENT_W = DATA_W + 2;
`else
  localparam int ENT_W = DATA_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              inflight_q;
  logic              busy_q, done_q;
  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  occ_q;
  logic [CNT_W:0]    credit_s;
  logic              rd_issue_s;
  logic              push_s;
  logic              pop_s;
  logic              valid_s;
  logic [ENT_W-1:0]  push_ent_s;
  logic [ENT_W-1:0]  head_s;
  logic              drained_s;
`ifdef PROC_0_PIXEL_READER_PACKET_EN
  logic              first_q, first_d;
  logic              inflight_sop_q, inflight_eop_q;
`endif

  // A read may only be issued if the FIFO has a free slot for it and for any word already returning.
  assign credit_s   = {1'b0, occ_q} + {{CNT_W{1'b0}}, inflight_q};
  assign rd_issue_s = (state_q == S_FETCH) && (credit_s < (CNT_W+1)'(FIFO_DEPTH));
  assign valid_s    = (occ_q != '0);
  assign pop_s      = valid_s & st_ready;
  assign push_s     = inflight_q;
  assign head_s     = fifo_q[rd_ptr_q];
  assign drained_s  = !inflight_q &&
                      ((occ_q == '0) || ((occ_q == CNT_W'(1)) && pop_s));

`ifdef PROC_0_PIXEL_READER_PACKET_EN
  assign push_ent_s = {inflight_sop_q, inflight_eop_q, mem_readdata};
  assign st_sop     = valid_s & head_s[DATA_W+1];
  assign st_eop     = valid_s & head_s[DATA_W];
`else
  assign push_ent_s = mem_readdata;
`endif

  assign st_data        = head_s[DATA_W-1:0];
  assign st_valid       = valid_s;
  assign mem_address    = addr_q;
  assign mem_chipselect = rd_issue_s;
  assign mem_write      = 1'b0;
  assign mem_byteenable = {(DATA_W/8){1'b1}};
  assign mem_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;

  // Next-state logic for the transfer controller.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
`ifdef PROC_0_PIXEL_READER_PACKET_EN
    first_d = first_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d  = base_addr;
            rem_d   = word_count;
            state_d = S_FETCH;
`ifdef PROC_0_PIXEL_READER_PACKET_EN
            first_d = 1'b1;
`endif
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (rd_issue_s) begin
          addr_d = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
`ifdef PROC_0_PIXEL_READER_PACKET_EN
          first_d = 1'b0;
`endif
          if (rem_q == ADDR_W'(1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Leave as the last buffered word is accepted so done lines up with that handshake.
        if (drained_s) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Controller registers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PROC_0_PIXEL_READER_PACKET_EN
      first_q        <= 1'b0;
      inflight_sop_q <= 1'b0;
      inflight_eop_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= rd_issue_s;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_FINISH);
`ifdef PROC_0_PIXEL_READER_PACKET_EN
      first_q        <= first_d;
      inflight_sop_q <= rd_issue_s & first_q;
      inflight_eop_q <= rd_issue_s & (rem_q == ADDR_W'(1));
`endif
    end
  end

  // Output FIFO: returning words are always pushed; the credit check keeps it from overflowing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= push_ent_s;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule
